arvi_bus_arbiter: RTL

//  N-master to 1-slave arbiter for the ARVI bus_if protocol; sits between core/IMEM/DMEM/DMA masters and the shared memory bus.

---
 rtl/arvi_bus_arbiter_pkg.sv | 26 ++
 rtl/arvi_bus_arbiter_rr_picker.sv | 37 +++
 rtl/arvi_bus_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/arvi_bus_arbiter_pkg.sv
// Shared types and helpers for the ARVI bus arbiter.
//   arb_state_t : arbiter FSM states
//   OP_W        : width of an RVA operation code
//   wrap_inc    : index + 1, wrapping at n
//   cnt_width   : counter width able to hold max(a, b) - 1
package arvi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  localparam int OP_W = 7;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/arvi_bus_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority index this round
//   grant out N      one-hot selected requester
//   idx   out IDX_W  index of selected requester
//   valid out 1      at least one request present
module arvi_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Walk from the farthest offset back to ptr so the nearest requester
  // at/after ptr is the last one written and therefore wins.
  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arvi_bus_arbiter.sv
// N-master to 1-slave round-robin arbiter for the ARVI bus_if protocol.
// Registered grant, pass-through slave fields and ack, grant held across
// atomic sequences, timeout error ack for a hung slave.
//   i_clk, i_rstn                   clock, async active-low reset
//   i_m_bus_en/wr_en/atomic  [N]    per-master request, write, atomic flag
//   i_m_addr/wr_data/byte_en/operation  packed per-master fields
//   o_m_ack, o_m_err         [N]    one-hot ack / error pulse to granted master
//   o_m_rd_data                     shared read data, valid with o_m_ack
//   o_s_*                           slave-side bus_if master signals
//   i_s_ack, i_s_rd_data            slave response
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// GRANT | owner's transfer presented to slave; waiting for ack or timeout
// LOCK  | atomic owner keeps the bus; waiting for its next request
module arvi_bus_arbiter
  import arvi_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256,
  parameter int LOCK_MAX  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [N_MASTERS-1:0]          i_m_bus_en,
  input  logic [N_MASTERS-1:0]          i_m_wr_en,
  input  logic [N_MASTERS*ADDR_W-1:0]   i_m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   i_m_wr_data,
  input  logic [N_MASTERS*DATA_W/8-1:0] i_m_byte_en,
  input  logic [N_MASTERS*OP_W-1:0]     i_m_operation,
  input  logic [N_MASTERS-1:0]          i_m_atomic,
  output logic [N_MASTERS-1:0]          o_m_ack,
  output logic [N_MASTERS-1:0]          o_m_err,
  output logic [DATA_W-1:0]             o_m_rd_data,
  output logic                          o_s_bus_en,
  output logic                          o_s_wr_en,
  output logic [ADDR_W-1:0]             o_s_addr,
  output logic [DATA_W-1:0]             o_s_wr_data,
  output logic [DATA_W/8-1:0]           o_s_byte_en,
  output logic [OP_W-1:0]               o_s_operation,
  output logic                          o_s_atomic,
  input  logic                          i_s_ack,
  input  logic [DATA_W-1:0]             i_s_rd_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = cnt_width(TIMEOUT, LOCK_MAX);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       g_idx, g_idx_nxt;
  logic [N_MASTERS-1:0]   g_oh, g_oh_nxt;
  logic [IDX_W-1:0]       rr_ptr, rr_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  logic [N_MASTERS-1:0]   pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   owner_req;
  logic                   active;
  logic                   timeout_hit;
  logic                   lock_done;
  logic [IDX_W-1:0]       rr_after;

  arvi_rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (i_m_bus_en),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_req   = i_m_bus_en[g_idx];
  assign active      = (state == GRANT) && owner_req;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign lock_done   = (cnt == CNT_W'(LOCK_MAX - 1));
  assign rr_after    = IDX_W'(wrap_inc(int'(g_idx), N_MASTERS));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      g_idx  <= '0;
      g_oh   <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      g_idx  <= g_idx_nxt;
      g_oh   <= g_oh_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // The counter is cleared by default, so every state change starts it at 0;
  // it only advances while waiting in GRANT or LOCK.
  always_comb begin
    state_nxt = state;
    g_idx_nxt = g_idx;
    g_oh_nxt  = g_oh;
    rr_nxt    = rr_ptr;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          g_idx_nxt = pick_idx;
          g_oh_nxt  = pick_oh;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (i_s_ack) begin
          rr_nxt    = rr_after;
          state_nxt = i_m_atomic[g_idx] ? LOCK : IDLE;
        end else if (timeout_hit) begin
          // A timed-out master has had its turn; move on so a hung slave
          // address cannot starve the others.
          rr_nxt    = rr_after;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOCK: begin
        if (owner_req) begin
          state_nxt = GRANT;
        end else if (!lock_done) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything on both sides is gated by an active grant, so reset or a
  // withdrawn request forces the outputs to zero in the same cycle.
  always_comb begin
    o_s_bus_en    = 1'b0;
    o_s_wr_en     = 1'b0;
    o_s_addr      = '0;
    o_s_wr_data   = '0;
    o_s_byte_en   = '0;
    o_s_operation = '0;
    o_s_atomic    = 1'b0;
    o_m_ack       = '0;
    o_m_err       = '0;
    o_m_rd_data   = '0;
    if (active) begin
      o_s_bus_en    = 1'b1;
      o_s_wr_en     = i_m_wr_en[g_idx];
      o_s_addr      = i_m_addr[int'(g_idx)*ADDR_W +: ADDR_W];
      o_s_wr_data   = i_m_wr_data[int'(g_idx)*DATA_W +: DATA_W];
      o_s_byte_en   = i_m_byte_en[int'(g_idx)*BE_W +: BE_W];
      o_s_operation = i_m_operation[int'(g_idx)*OP_W +: OP_W];
      o_s_atomic    = i_m_atomic[g_idx];
      if (i_s_ack) begin
        o_m_ack     = g_oh;
        o_m_rd_data = i_s_rd_data;
      end else if (timeout_hit) begin
        o_m_ack = g_oh;
        o_m_err = g_oh;
      end else begin
        o_m_rd_data = i_s_rd_data;
      end
    end
  end

endmodule
